// File: rtl/load_store_multi.sv
// rtl/load_store_multi.sv - multi-channel triangle/sawtooth volume oscillator with peak-event counters
module load_store_multi #(
    parameter int CHANNELS = 4,
    parameter int CBITS    = 10,
    parameter int N        = 750,
    parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int EBITS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       clr,
    input  logic                      lim_we,
    input  logic [SELW-1:0]           lim_sel,
    input  logic [CBITS-1:0]          lim_val,
    output logic [CHANNELS*CBITS-1:0] vol_o,
    output logic [CHANNELS-1:0]       sig,
    output logic [CHANNELS-1:0]       low,
    output logic [CHANNELS*EBITS-1:0] peaks
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CBITS-1:0] vol_q;
        logic [CBITS-1:0] lim_q;
        logic [EBITS-1:0] pk_q;
        logic             m_q;
        logic             sig_q;
        logic             low_q;
        logic [CBITS-1:0] nvol;
        logic             nm;
        logic             nsig;
        logic             nlow;
        logic             lim_hit;

        // Only selects that name an existing channel match, so out-of-range writes fall away.
        assign lim_hit = lim_we && (lim_sel == SELW'(g));

        always_comb begin
            nvol = vol_q;
            nm   = m_q;
            if (clr[g]) begin
                nvol = '0;
                nm   = 1'b0;
            end else if (en[g]) begin
                if (mode) begin
                    nm   = 1'b1;
                    nvol = (vol_q >= lim_q) ? '0 : vol_q + 1'b1;
                end else if (m_q) begin
                    if (vol_q >= lim_q) begin
                        nm = 1'b0;
                    end else begin
                        nvol = vol_q + 1'b1;
                    end
                end else begin
                    if (vol_q == '0) begin
                        nm = 1'b1;
                    end else begin
                        nvol = vol_q - 1'b1;
                    end
                end
            end
            // Flags follow the post-update count even when the channel is frozen.
            nsig = (nvol == lim_q);
            nlow = (nvol == '0);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vol_q <= '0;
                m_q   <= 1'b0;
                lim_q <= CBITS'(N);
                pk_q  <= '0;
                sig_q <= 1'b0;
                low_q <= 1'b0;
            end else begin
                vol_q <= nvol;
                m_q   <= nm;
                sig_q <= nsig;
                low_q <= nlow;
                if (lim_hit) begin
                    lim_q <= lim_val;
                end
                if (clr[g]) begin
                    pk_q <= '0;
                end else if (nsig && !sig_q) begin
                    pk_q <= pk_q + 1'b1;
                end
            end
        end

        assign vol_o[g*CBITS +: CBITS] = vol_q;
        assign peaks[g*EBITS +: EBITS] = pk_q;
        assign sig[g]                  = sig_q;
        assign low[g]                  = low_q;
    end

endmodule

// File: tb/tb_load_store_multi.sv
// tb/tb_load_store_multi.sv - directed table-driven bench for load_store_multi
module tb_load_store_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        mode;
    logic [3:0]  clr;
    logic        lim_we;
    logic [1:0]  lim_sel;
    logic [9:0]  lim_val;
    logic [39:0] vol_o;
    logic [3:0]  sig;
    logic [3:0]  low;
    logic [31:0] peaks;

    logic [2:0]  en3;
    logic        mode3;
    logic [2:0]  clr3;
    logic        lim_we3;
    logic [1:0]  lim_sel3;
    logic [3:0]  lim_val3;
    logic [11:0] vol_o3;
    logic [2:0]  sig3;
    logic [2:0]  low3;
    logic [11:0] peaks3;

    int checks;
    int failures;

    load_store_multi dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr),
        .lim_we(lim_we), .lim_sel(lim_sel), .lim_val(lim_val),
        .vol_o(vol_o), .sig(sig), .low(low), .peaks(peaks)
    );

    load_store_multi #(.CHANNELS(3), .CBITS(4), .N(5), .EBITS(4)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .mode(mode3), .clr(clr3),
        .lim_we(lim_we3), .lim_sel(lim_sel3), .lim_val(lim_val3),
        .vol_o(vol_o3), .sig(sig3), .low(low3), .peaks(peaks3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic       mode;
        logic       we;
        logic [1:0] sel;
        logic [9:0] val;
        logic [9:0] ev2;
        logic       es2;
        logic       el2;
        logic [9:0] ev0;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [9:0] v(input int i);
        return vol_o[i*10 +: 10];
    endfunction

    function automatic logic [7:0] pk(input int i);
        return peaks[i*8 +: 8];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = '0;
        mode     = 1'b0;
        clr      = '0;
        lim_we   = 1'b0;
        lim_sel  = '0;
        lim_val  = '0;
        en3      = '0;
        mode3    = 1'b0;
        clr3     = '0;
        lim_we3  = 1'b0;
        lim_sel3 = '0;
        lim_val3 = '0;
        #3;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0] = '{4'b0000, 1'b1, 1'b1, 2'd2, 10'd3, 10'd0, 1'b0, 1'b1, 10'd0};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd1, 1'b0, 1'b0, 10'd0};
        tbl[2] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd2, 1'b0, 1'b0, 10'd0};
        tbl[3] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd3, 1'b1, 1'b0, 10'd0};
        tbl[4] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0};
        tbl[5] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd1, 1'b0, 1'b0, 10'd0};
        tbl[6] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd2, 1'b0, 1'b0, 10'd0};
        tbl[7] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd3, 1'b1, 1'b0, 10'd0};
        tbl[8] = '{4'b0000, 1'b1, 1'b0, 2'd0, 10'd0, 10'd3, 1'b1, 1'b0, 10'd0};
        tbl[9] = '{4'b0100, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0};

        // Reset defaults and a full triangle sweep on every channel
        do_reset();
        chk("reset_vol", vol_o, 40'd0);
        chk("reset_sig", sig, 4'd0);
        chk("reset_low", low, 4'd0);
        chk("reset_peaks", peaks, 32'd0);
        en = 4'hF;
        tick(1);
        chk("tri_c1_vol", vol_o, 40'd0);
        chk("tri_c1_low", low, 4'hF);
        tick(750);
        for (int i = 0; i < 4; i++) chk($sformatf("tri_c751_vol%0d", i), v(i), 10'd750);
        chk("tri_c751_sig", sig, 4'hF);
        tick(1);
        chk("tri_c752_vol0", v(0), 10'd750);
        chk("tri_c752_sig", sig, 4'hF);
        tick(1);
        chk("tri_c753_vol0", v(0), 10'd749);
        chk("tri_c753_sig", sig, 4'h0);
        tick(749);
        for (int i = 0; i < 4; i++) chk($sformatf("tri_bottom_vol%0d", i), v(i), 10'd0);
        chk("tri_bottom_low", low, 4'hF);
        chk("tri_peaks", peaks, {8'd1, 8'd1, 8'd1, 8'd1});

        // Sawtooth on ch2 with limit 3, driven from the vector table
        do_reset();
        for (int k = 0; k < 10; k++) begin
            en      = tbl[k].en;
            mode    = tbl[k].mode;
            lim_we  = tbl[k].we;
            lim_sel = tbl[k].sel;
            lim_val = tbl[k].val;
            tick(1);
            chk($sformatf("saw_v%0d_vol2", k), v(2), tbl[k].ev2);
            chk($sformatf("saw_v%0d_sig2", k), sig[2], tbl[k].es2);
            chk($sformatf("saw_v%0d_low2", k), low[2], tbl[k].el2);
            chk($sformatf("saw_v%0d_vol0", k), v(0), tbl[k].ev0);
        end
        chk("saw_peaks2", pk(2), 8'd2);
        chk("saw_peaks0", pk(0), 8'd0);

        // Ch1 limit lowered below the live count while climbing
        do_reset();
        en = 4'b0010;
        tick(501);
        chk("lower_vol1_start", v(1), 10'd500);
        en      = 4'b0000;
        lim_we  = 1'b1;
        lim_sel = 2'd1;
        lim_val = 10'd100;
        tick(1);
        lim_we = 1'b0;
        chk("lower_write_vol1", v(1), 10'd500);
        chk("lower_write_sig1", sig[1], 1'b0);
        en = 4'b0010;
        tick(1);
        chk("lower_turn_vol1", v(1), 10'd500);
        chk("lower_turn_sig1", sig[1], 1'b0);
        tick(1);
        chk("lower_desc_vol1", v(1), 10'd499);

        // Limit zero on ch0 in triangle mode
        do_reset();
        lim_we  = 1'b1;
        lim_sel = 2'd0;
        lim_val = 10'd0;
        tick(1);
        lim_we = 1'b0;
        en     = 4'b0001;
        tick(1);
        chk("lim0_first_sig0", sig[0], 1'b1);
        tick(4);
        chk("lim0_vol0", v(0), 10'd0);
        chk("lim0_sig0", sig[0], 1'b1);
        chk("lim0_low0", low[0], 1'b1);
        chk("lim0_peaks0", pk(0), 8'd1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_vol", vol_o, 40'd0);
        chk("async_sig", sig, 4'd0);
        chk("async_low", low, 4'd0);
        chk("async_peaks", peaks, 32'd0);

        // Clear on ch0 alone
        do_reset();
        en = 4'hF;
        tick(5);
        chk("clr_pre_vol", vol_o, {10'd4, 10'd4, 10'd4, 10'd4});
        clr = 4'b0001;
        tick(1);
        clr = 4'b0000;
        chk("clr_vol", vol_o, {10'd5, 10'd5, 10'd5, 10'd0});
        chk("clr_low0", low[0], 1'b1);

        // Ch3 frozen at 37 then resumed upward
        do_reset();
        en = 4'b1000;
        tick(38);
        chk("freeze_start_vol3", v(3), 10'd37);
        en = 4'b0000;
        tick(10);
        chk("freeze_hold_vol3", v(3), 10'd37);
        en = 4'b1000;
        tick(1);
        chk("freeze_resume_vol3", v(3), 10'd38);
        tick(1);
        chk("freeze_resume2_vol3", v(3), 10'd39);

        // Out-of-range limit select on the three-channel instance
        do_reset();
        lim_we3  = 1'b1;
        lim_sel3 = 2'd3;
        lim_val3 = 4'd1;
        tick(1);
        lim_we3 = 1'b0;
        en3     = 3'b111;
        tick(6);
        chk("oor_vol", vol_o3, {4'd5, 4'd5, 4'd5});
        chk("oor_sig", sig3, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
